// File: rtl/directory_update_writer.sv
// In-order update queue feeding the directory L2 bank / PLRU write port. One write pulse per entry, one entry per cycle.
// Optional DC_UPDATE_COALESCE_EN: a push hitting the youngest queued {set,way} merges into it instead of allocating.
module directory_update_writer #(
   parameter int FIFO_DEPTH = 4,
   parameter int SET_W      = 8,
   parameter int WAY_W      = 3,
   parameter int SHR_W      = 16,
   parameter int OWN_W      = 4,
   parameter int LINE_W     = 64
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          upd_valid,
   output logic                          upd_ready,
   input  logic                          upd_cache_en,
   input  logic                          upd_plru_en,
   input  logic [SET_W-1:0]              upd_set,
   input  logic [WAY_W-1:0]              upd_way,
   input  logic [SHR_W-1:0]              upd_sharers,
   input  logic [OWN_W-1:0]              upd_owner,
   input  logic [LINE_W-1:0]             upd_data,
   input  logic                          wr_hold,
   input  logic [SET_W-1:0]              lookup_set,
   output logic                          set_conflict,
   output logic                          dc3_update_cache_enable,
   output logic [SET_W-1:0]              dc3_update_cache_set,
   output logic [WAY_W-1:0]              dc3_update_cache_way,
   output logic [SHR_W-1:0]              dc3_update_cache_sharers_list,
   output logic [OWN_W-1:0]              dc3_update_cache_owner,
   output logic [LINE_W-1:0]             dc3_update_cache_data,
   output logic                          dc3_update_plru_en,
   output logic [SET_W-1:0]              dc3_update_plru_set,
   output logic [WAY_W-1:0]              dc3_update_plru_way,
   output logic [$clog2(FIFO_DEPTH):0]   occupancy
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic              cache_en;
      logic              plru_en;
      logic [SET_W-1:0]  line_set;
      logic [WAY_W-1:0]  line_way;
      logic [SHR_W-1:0]  sharers;
      logic [OWN_W-1:0]  owner;
      logic [LINE_W-1:0] data;
   } entry_t;

   entry_t           mem_q [FIFO_DEPTH];
   entry_t           mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   entry_t           out_q, out_d;
   entry_t           new_ent, pop_ent;
   logic             empty, full, merge_hit, push, pop, pop_from_q, alloc, hit_q;

   assign new_ent = '{cache_en: upd_cache_en, plru_en: upd_plru_en, line_set: upd_set,
                      line_way: upd_way, sharers: upd_sharers, owner: upd_owner, data: upd_data};

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));

`ifdef DC_UPDATE_COALESCE_EN
   logic [PTR_W-1:0] young_ptr;
   assign young_ptr = wr_ptr_q - PTR_W'(1);
   // The youngest entry is off limits only when it is also the head being popped now.
   assign merge_hit = !empty && (mem_q[young_ptr].line_set == upd_set) &&
                      (mem_q[young_ptr].line_way == upd_way) &&
                      !(!wr_hold && (cnt_q == CNT_W'(1)));
   assign upd_ready = !full || merge_hit;
`else
   assign merge_hit = 1'b0;
   assign upd_ready = !full;
`endif

   assign push = upd_valid && upd_ready && (upd_cache_en || upd_plru_en);

   always_comb begin
      mem_d          = mem_q;
      rd_ptr_d       = rd_ptr_q;
      wr_ptr_d       = wr_ptr_q;
      out_d          = out_q;
      out_d.cache_en = 1'b0;
      out_d.plru_en  = 1'b0;
      // An empty queue lets the incoming push go straight to the output register.
      pop_ent        = empty ? new_ent : mem_q[rd_ptr_q];
      pop            = !wr_hold && (!empty || push);
      pop_from_q     = pop && !empty;
      alloc          = push && !merge_hit && !(empty && pop);
      if (pop) out_d = pop_ent;
      if (pop_from_q) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (alloc) begin
         mem_d[wr_ptr_q] = new_ent;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
`ifdef DC_UPDATE_COALESCE_EN
      if (push && merge_hit) begin
         mem_d[young_ptr].cache_en = mem_q[young_ptr].cache_en | upd_cache_en;
         mem_d[young_ptr].plru_en  = mem_q[young_ptr].plru_en | upd_plru_en;
         if (upd_cache_en) begin
            mem_d[young_ptr].sharers = upd_sharers;
            mem_d[young_ptr].owner   = upd_owner;
            mem_d[young_ptr].data    = upd_data;
         end
      end
`endif
      cnt_d = cnt_q + CNT_W'(alloc) - CNT_W'(pop_from_q);
   end

   always_comb begin
      logic [PTR_W-1:0] idx;
      hit_q = 1'b0;
      idx   = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         idx = rd_ptr_q + PTR_W'(i);
         if ((CNT_W'(i) < cnt_q) && (mem_q[idx].line_set == lookup_set)) hit_q = 1'b1;
      end
   end

   assign set_conflict = hit_q ||
                         ((out_q.cache_en || out_q.plru_en) && (out_q.line_set == lookup_set)) ||
                         (push && (upd_set == lookup_set));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         out_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         out_q    <= out_d;
      end
   end

   assign dc3_update_cache_enable       = out_q.cache_en;
   assign dc3_update_cache_set          = out_q.line_set;
   assign dc3_update_cache_way          = out_q.line_way;
   assign dc3_update_cache_sharers_list = out_q.sharers;
   assign dc3_update_cache_owner        = out_q.owner;
   assign dc3_update_cache_data         = out_q.data;
   assign dc3_update_plru_en            = out_q.plru_en;
   assign dc3_update_plru_set           = out_q.line_set;
   assign dc3_update_plru_way           = out_q.line_way;
   assign occupancy                     = cnt_q;

endmodule

// File: tb/tb_directory_update_writer.sv
// Bench for directory_update_writer: queue-level model checked every cycle plus directed literal expectations.
module tb_directory_update_writer;
   localparam int DEPTH = 4;

   logic        clk, reset;
   logic        upd_valid, upd_ready, upd_cache_en, upd_plru_en;
   logic [7:0]  upd_set, lookup_set;
   logic [2:0]  upd_way;
   logic [15:0] upd_sharers;
   logic [3:0]  upd_owner;
   logic [63:0] upd_data;
   logic        wr_hold, set_conflict;
   logic        c_en, p_en;
   logic [7:0]  c_set, p_set;
   logic [2:0]  c_way, p_way;
   logic [15:0] c_shr;
   logic [3:0]  c_own;
   logic [63:0] c_data;
   logic [2:0]  occupancy;

   int checks = 0;
   int errors = 0;

   localparam logic [63:0] DA = 64'hA5A5_0000_1111_2222;
   localparam logic [63:0] DB = 64'h5A5A_3333_4444_5555;

   directory_update_writer #(.FIFO_DEPTH(DEPTH), .SET_W(8), .WAY_W(3), .SHR_W(16),
                             .OWN_W(4), .LINE_W(64)) dut (
      .clk(clk), .reset(reset),
      .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_cache_en(upd_cache_en), .upd_plru_en(upd_plru_en),
      .upd_set(upd_set), .upd_way(upd_way), .upd_sharers(upd_sharers),
      .upd_owner(upd_owner), .upd_data(upd_data),
      .wr_hold(wr_hold), .lookup_set(lookup_set), .set_conflict(set_conflict),
      .dc3_update_cache_enable(c_en), .dc3_update_cache_set(c_set),
      .dc3_update_cache_way(c_way), .dc3_update_cache_sharers_list(c_shr),
      .dc3_update_cache_owner(c_own), .dc3_update_cache_data(c_data),
      .dc3_update_plru_en(p_en), .dc3_update_plru_set(p_set), .dc3_update_plru_way(p_way),
      .occupancy(occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a queue of pending writes; each cycle an accepted push joins the tail,
   // then, unless held, the head leaves as that cycle's write pulse.
   typedef struct {
      logic        c, p;
      logic [7:0]  set;
      logic [2:0]  way;
      logic [15:0] shr;
      logic [3:0]  own;
      logic [63:0] data;
   } ent_t;

   ent_t        q[$];
   logic        m_c = 1'b0, m_p = 1'b0;
   logic [7:0]  m_set = '0;
   logic [2:0]  m_way = '0;
   logic [15:0] m_shr = '0;
   logic [3:0]  m_own = '0;
   logic [63:0] m_data = '0;

   function automatic bit m_merge();
`ifdef DC_UPDATE_COALESCE_EN
      if (q.size() == 0) return 1'b0;
      return (q[q.size()-1].set == upd_set) && (q[q.size()-1].way == upd_way) &&
             !(!wr_hold && q.size() == 1);
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit m_ready();
      return (q.size() < DEPTH) || m_merge();
   endfunction

   always @(posedge clk or posedge reset) begin
      ent_t e;
      bit   mrg;
      if (reset) begin
         q.delete();
         m_c = 0; m_p = 0; m_set = '0; m_way = '0; m_shr = '0; m_own = '0; m_data = '0;
      end else begin
         mrg = m_merge();
         if (upd_valid && m_ready() && (upd_cache_en || upd_plru_en)) begin
            if (mrg) begin
               q[q.size()-1].c = q[q.size()-1].c | upd_cache_en;
               q[q.size()-1].p = q[q.size()-1].p | upd_plru_en;
               if (upd_cache_en) begin
                  q[q.size()-1].shr  = upd_sharers;
                  q[q.size()-1].own  = upd_owner;
                  q[q.size()-1].data = upd_data;
               end
            end else begin
               e.c = upd_cache_en; e.p = upd_plru_en; e.set = upd_set; e.way = upd_way;
               e.shr = upd_sharers; e.own = upd_owner; e.data = upd_data;
               q.push_back(e);
            end
         end
         if (!wr_hold && q.size() > 0) begin
            e = q.pop_front();
            m_c = e.c; m_p = e.p; m_set = e.set; m_way = e.way;
            m_shr = e.shr; m_own = e.own; m_data = e.data;
         end else begin
            m_c = 0; m_p = 0;
         end
      end
   end

   always @(negedge clk) begin
      bit conf;
      conf = 1'b0;
      foreach (q[i]) if (q[i].set == lookup_set) conf = 1'b1;
      if ((m_c || m_p) && m_set == lookup_set) conf = 1'b1;
      if (upd_valid && m_ready() && (upd_cache_en || upd_plru_en) && upd_set == lookup_set)
         conf = 1'b1;
      chk("upd_ready", 64'(upd_ready), 64'(m_ready()));
      chk("set_conflict", 64'(set_conflict), 64'(conf));
      chk("occupancy", 64'(occupancy), 64'(q.size()));
      chk("cache_enable", 64'(c_en), 64'(m_c));
      chk("plru_en", 64'(p_en), 64'(m_p));
      chk("cache_set", 64'(c_set), 64'(m_set));
      chk("cache_way", 64'(c_way), 64'(m_way));
      chk("plru_set", 64'(p_set), 64'(m_set));
      chk("plru_way", 64'(p_way), 64'(m_way));
      chk("sharers", 64'(c_shr), 64'(m_shr));
      chk("owner", 64'(c_own), 64'(m_own));
      chk("data", c_data, m_data);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic req(bit v, bit c, bit p, logic [7:0] s, logic [2:0] w, logic [63:0] d);
      upd_valid    = v;
      upd_cache_en = c;
      upd_plru_en  = p;
      upd_set      = s;
      upd_way      = w;
      upd_data     = d;
      upd_sharers  = d[15:0];
      upd_owner    = d[19:16];
   endtask

   task automatic idle();
      req(1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 64'd0);
   endtask

   initial begin
      reset = 1'b1;
      wr_hold = 1'b0;
      lookup_set = 8'd0;
      idle();
      tick(); tick();
      chk("rst_ready", 64'(upd_ready), 64'd1);
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      chk("rst_cache_en", 64'(c_en), 64'd0);
      chk("rst_data", c_data, 64'd0);
      reset = 1'b0;
      lookup_set = 8'd99;
      tick();

      // single write, visible one cycle after the push
      req(1'b1, 1'b1, 1'b1, 8'd5, 3'd2, DA);
      tick();
      idle();
      chk("single_cache_en", 64'(c_en), 64'd1);
      chk("single_plru_en", 64'(p_en), 64'd1);
      chk("single_set", 64'(c_set), 64'd5);
      chk("single_way", 64'(c_way), 64'd2);
      chk("single_data", c_data, DA);
      tick();
      chk("single_pulse_end", 64'(c_en), 64'd0);
      chk("single_set_held", 64'(c_set), 64'd5);

      // fill under hold, refuse a fifth push, then drain in order
      wr_hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req(1'b1, 1'b1, 1'b0, 8'(10 + i), 3'(i), DB + 64'(i));
         tick();
      end
      chk("fill_occupancy", 64'(occupancy), 64'd4);
      chk("fill_ready", 64'(upd_ready), 64'd0);
      req(1'b1, 1'b1, 1'b1, 8'd14, 3'd7, DA);
      tick();
      chk("fill_refused", 64'(occupancy), 64'd4);
      idle();
      wr_hold = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("drain_strobe", 64'(c_en), 64'd1);
         chk("drain_order", 64'(c_set), 64'(10 + i));
      end
      tick();
      chk("drain_done", 64'(c_en), 64'd0);

      // set conflict
      wr_hold = 1'b1;
      req(1'b1, 1'b1, 1'b1, 8'd7, 3'd0, DA);
      tick();
      idle();
      lookup_set = 8'd7;
      #1 chk("conflict_hit", 64'(set_conflict), 64'd1);
      lookup_set = 8'd8;
      #1 chk("conflict_miss", 64'(set_conflict), 64'd0);
      lookup_set = 8'd7;
      wr_hold = 1'b0;
      tick();
      chk("conflict_out_reg", 64'(set_conflict), 64'd1);
      tick();
      chk("conflict_drained", 64'(set_conflict), 64'd0);

      // plru-only, then dropped request
      req(1'b1, 1'b0, 1'b1, 8'd20, 3'd3, DB);
      tick();
      idle();
      chk("plru_only_p", 64'(p_en), 64'd1);
      chk("plru_only_c", 64'(c_en), 64'd0);
      req(1'b1, 1'b0, 1'b0, 8'd21, 3'd4, DA);
      tick();
      idle();
      tick();
      chk("drop_strobe", 64'(c_en | p_en), 64'd0);
      chk("drop_occupancy", 64'(occupancy), 64'd0);

      // reset while draining
      wr_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req(1'b1, 1'b1, 1'b1, 8'(30 + i), 3'(i), DA);
         tick();
      end
      idle();
      wr_hold = 1'b0;
      tick();
      chk("pre_reset_strobe", 64'(c_en), 64'd1);
      reset = 1'b1;
      #1;
      chk("mid_reset_strobe", 64'(c_en | p_en), 64'd0);
      chk("mid_reset_occupancy", 64'(occupancy), 64'd0);
      chk("mid_reset_ready", 64'(upd_ready), 64'd1);
      tick();
      reset = 1'b0;
      tick();

      // same set/way twice under hold
      wr_hold = 1'b1;
      req(1'b1, 1'b1, 1'b1, 8'd3, 3'd1, DA);
      tick();
      req(1'b1, 1'b1, 1'b1, 8'd3, 3'd1, DB);
      tick();
      idle();
`ifdef DC_UPDATE_COALESCE_EN
      chk("coalesce_occupancy", 64'(occupancy), 64'd1);
`else
      chk("coalesce_occupancy", 64'(occupancy), 64'd2);
`endif
      wr_hold = 1'b0;
      tick();
      chk("coalesce_first_en", 64'(c_en), 64'd1);
`ifdef DC_UPDATE_COALESCE_EN
      chk("coalesce_first_data", c_data, DB);
      tick();
      chk("coalesce_single", 64'(c_en), 64'd0);
`else
      chk("coalesce_first_data", c_data, DA);
      tick();
      chk("coalesce_second_en", 64'(c_en), 64'd1);
      chk("coalesce_second_data", c_data, DB);
`endif
      tick();

      // mixed traffic with intermittent hold, checked by the model
      for (int i = 0; i < 40; i++) begin
         wr_hold    = (i % 5 == 3) || (i % 7 == 0) || (i >= 12 && i < 17);
         lookup_set = 8'(7 + i % 5);
         req(i % 4 != 3, i % 2 == 0, i % 3 != 1, 8'(7 + i % 4), 3'(i % 3),
             64'(i) * 64'h0101_0101_0101_0101);
         tick();
      end
      idle();
      wr_hold = 1'b0;
      repeat (8) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
